// File: rtl/sirv_uartrx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: non-stallable enqueue, valid/ready dequeue,
// watermark and sticky overflow flags. Optional idle timeout enabled by SIRV_UARTRX_FIFO_TMO_EN.
module sirv_uartrx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          io_en,
  input  logic          io_enq_valid,
  input  logic [7:0]    io_enq_bits,
  output logic          io_deq_valid,
  input  logic          io_deq_ready,
  output logic [7:0]    io_deq_bits,
  input  logic          io_flush,
  input  logic [AW-1:0] io_rxwm,
  output logic          io_ip_rxwm,
  output logic [AW:0]   io_count,
  output logic          io_overflow,
  input  logic          io_clr_ovf,
  input  logic [15:0]   io_tmo_cycles,
  output logic          io_ip_tmo
);

  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] count;
  logic          overflow;
  logic          enq;
  logic          deq;
  logic          full;
  logic          accept;
  logic          drop;

  // Flush overrides both ports, so it also suppresses writes and overflow marking.
  assign enq    = io_en & io_enq_valid;
  assign deq    = io_deq_valid & io_deq_ready;
  assign full   = (count == FULL_CNT);
  assign accept = enq & ~io_flush & (~full | deq);
  assign drop   = enq & ~io_flush & full & ~deq;

  assign io_deq_valid = (count != '0);
  assign io_deq_bits  = mem[rp];
  assign io_ip_rxwm   = (count > CW'(io_rxwm));
  assign io_count     = count;
  assign io_overflow  = overflow;

  // Pointer and occupancy tracking
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (io_flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (accept) wp <= wp + AW'(1);
      if (deq)    rp <= rp + AW'(1);
      if (accept && !deq)      count <= count + CW'(1);
      else if (deq && !accept) count <= count - CW'(1);
    end
  end

  // Byte storage; contents need no reset since pointers define validity
  always_ff @(posedge clock) begin
    if (accept) mem[wp] <= io_enq_bits;
  end

  // Sticky overflow: a new loss wins over a simultaneous clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           overflow <= 1'b0;
    else if (drop)       overflow <= 1'b1;
    else if (io_clr_ovf) overflow <= 1'b0;
  end

`ifdef SIRV_UARTRX_FIFO_TMO_EN
  logic [15:0] idle;
  logic        ip_tmo;
  logic        tmo_hit;

  assign tmo_hit   = (count != '0) && (io_tmo_cycles != 16'd0) && (idle == io_tmo_cycles);
  assign io_ip_tmo = ip_tmo;

  // Idle counter saturates so a long-quiet FIFO keeps its pending flag stable
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle   <= 16'd0;
      ip_tmo <= 1'b0;
    end else begin
      if (accept || deq || io_flush || (count == '0)) idle <= 16'd0;
      else if (idle != 16'hFFFF)                      idle <= idle + 16'd1;
      if (deq || io_flush) ip_tmo <= 1'b0;
      else if (tmo_hit)    ip_tmo <= 1'b1;
    end
  end
`else
  logic unused_tmo_cycles;
  assign unused_tmo_cycles = ^io_tmo_cycles;
  assign io_ip_tmo         = 1'b0;
`endif

endmodule

// File: tb/tb_sirv_uartrx_fifo.sv
// Self-checking bench for sirv_uartrx_fifo: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_sirv_uartrx_fifo;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        enq_valid = 1'b0;
  logic [7:0]  enq_bits = 8'h00;
  logic        deq_valid;
  logic        deq_ready = 1'b0;
  logic [7:0]  deq_bits;
  logic        flush = 1'b0;
  logic [2:0]  rxwm = 3'd0;
  logic        ip_rxwm;
  logic [3:0]  count;
  logic        overflow;
  logic        clr_ovf = 1'b0;
  logic [15:0] tmo_cycles = 16'd0;
  logic        ip_tmo;

  int vectors = 0;
  int errors  = 0;

  sirv_uartrx_fifo #(.DEPTH(8), .AW(3)) dut (
    .clock(clock), .reset(reset), .io_en(en), .io_enq_valid(enq_valid),
    .io_enq_bits(enq_bits), .io_deq_valid(deq_valid), .io_deq_ready(deq_ready),
    .io_deq_bits(deq_bits), .io_flush(flush), .io_rxwm(rxwm), .io_ip_rxwm(ip_rxwm),
    .io_count(count), .io_overflow(overflow), .io_clr_ovf(clr_ovf),
    .io_tmo_cycles(tmo_cycles), .io_ip_tmo(ip_tmo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus flags, advanced from the spec's rules each clock
  logic [7:0] q[$];
  logic       m_ovf  = 1'b0;
  logic       m_tmo  = 1'b0;
  int         m_idle = 0;
  int         n;
  logic       e, d, acc, hit;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
      m_ovf  = 1'b0;
      m_tmo  = 1'b0;
      m_idle = 0;
    end else begin
      n   = q.size();
      e   = en & enq_valid;
      d   = (n != 0) & deq_ready;
      hit = (n != 0) && (tmo_cycles != 16'd0) && (m_idle == int'(tmo_cycles));
      acc = 1'b0;
      if (flush) q.delete();
      else begin
        acc = e && (n < 8 || d);
        if (d) void'(q.pop_front());
        if (acc) q.push_back(enq_bits);
      end
      if (!flush && e && !acc) m_ovf = 1'b1;
      else if (clr_ovf)        m_ovf = 1'b0;
      if (acc || d || flush || n == 0) m_idle = 0;
      else if (m_idle < 65535)         m_idle++;
      if (d || flush) m_tmo = 1'b0;
      else if (hit)   m_tmo = 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    if (!reset) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("deq_valid", 32'(deq_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("deq_bits", 32'(deq_bits), 32'(q[0]));
      chk("ip_rxwm", 32'(ip_rxwm), 32'(q.size() > int'(rxwm)));
      chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef SIRV_UARTRX_FIFO_TMO_EN
      chk("ip_tmo", 32'(ip_tmo), 32'(m_tmo));
`else
      chk("ip_tmo", 32'(ip_tmo), 32'd0);
`endif
    end
  end

  // One clock with the given inputs; returns at posedge+1 with strobes cleared
  task automatic step(input logic v, input logic [7:0] b, input logic rdy,
                      input logic fl, input logic clr);
    enq_valid = v; enq_bits = b; deq_ready = rdy; flush = fl; clr_ovf = clr;
    @(posedge clock); #1;
    enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_expect(input string name, input logic [7:0] b);
    chk(name, 32'(deq_bits), 32'(b));
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("reset count", 32'(count), 32'd0);
    chk("reset deq_valid", 32'(deq_valid), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset ip_rxwm", 32'(ip_rxwm), 32'd0);
    chk("reset ip_tmo", 32'(ip_tmo), 32'd0);
    reset = 1'b0;
    en    = 1'b1;
    rxwm  = 3'd7;

    // Fill/drain
    for (int i = 1; i <= 8; i++) push(8'(i));
    chk("fill count", 32'(count), 32'd8);
    for (int i = 1; i <= 8; i++) pop_expect("drain order", 8'(i));
    chk("drained count", 32'(count), 32'd0);
    chk("drained valid", 32'(deq_valid), 32'd0);

    // Overflow and clear
    for (int i = 0; i < 9; i++) push(8'h11 + 8'(i));
    chk("ovf set", 32'(overflow), 32'd1);
    chk("ovf head", 32'(deq_bits), 32'h11);
    chk("ovf count", 32'(count), 32'd8);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) pop_expect("ovf drain", 8'h11 + 8'(i));

    // Full with simultaneous enq and deq
    for (int i = 0; i < 8; i++) push(8'h21 + 8'(i));
    step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    chk("full enq+deq count", 32'(count), 32'd8);
    chk("full enq+deq ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 8; i++) pop_expect("full drain", 8'h21 + 8'(i));
    pop_expect("last byte", 8'hAA);

    // Watermark and flush
    rxwm = 3'd3;
    for (int i = 0; i < 3; i++) push(8'h30 + 8'(i));
    chk("wm below", 32'(ip_rxwm), 32'd0);
    push(8'h33);
    chk("wm reached", 32'(ip_rxwm), 32'd1);
    chk("wm count", 32'(count), 32'd4);
    step(1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
    chk("flush count", 32'(count), 32'd0);
    chk("flush wm", 32'(ip_rxwm), 32'd0);
    chk("flush valid", 32'(deq_valid), 32'd0);
    rxwm = 3'd0;
    push(8'h55);
    chk("wm zero", 32'(ip_rxwm), 32'd1);
    pop_expect("after flush", 8'h55);

    // Enable off
    en = 1'b0;
    for (int i = 0; i < 3; i++) push(8'h60);
    chk("disabled count", 32'(count), 32'd0);
    en = 1'b1;

    // Mixed traffic
    for (int i = 0; i < 80; i++) begin
      rxwm = 3'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 30) == 0), 1'($urandom_range(0, 10) == 0));
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("mixed flush", 32'(count), 32'd0);

`ifdef SIRV_UARTRX_FIFO_TMO_EN
    // Idle timeout
    tmo_cycles = 16'd20;
    push(8'h77);
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("tmo early", 32'(ip_tmo), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("tmo set", 32'(ip_tmo), 32'd1);
    pop_expect("tmo byte", 8'h77);
    chk("tmo cleared", 32'(ip_tmo), 32'd0);
    tmo_cycles = 16'd0;
`endif

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) push(8'h80 + 8'(i));
    chk("pre-reset count", 32'(count), 32'd5);
    #3 reset = 1'b1;
    #1;
    chk("async reset count", 32'(count), 32'd0);
    chk("async reset valid", 32'(deq_valid), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    push(8'h99);
    pop_expect("post-reset", 8'h99);

    repeat (2) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
